character_motion: RTL and testbench
===================================

CHARACTER_MOTION -- requirements
Module: character_motion

Interface
REQ-001 SHALL provide parameter X_MIN, default 203, leftmost playfield column.
REQ-002 SHALL provide parameter X_MAX, default 436, rightmost playfield column.
REQ-003 SHALL provide parameter Y_MIN, default 152, topmost playfield row.
REQ-004 SHALL provide parameter Y_MAX, default 327, bottommost playfield row (floor).
REQ-005 SHALL provide parameter SIZE, default 4, half-extent of normal sprite box.
REQ-006 SHALL provide parameter FULL_SIZE, default 8, half-extent while full.
REQ-007 SHALL provide parameter STEP, default 1, horizontal pixels per frame.
REQ-008 SHALL provide parameter JUMP_V, default 6, initial upward speed.
REQ-009 SHALL provide parameter MAX_FALL, default 6, downward speed cap.
REQ-010 SHALL provide parameter INHALE_FRAMES, default 30, frames of held inhale to become full.
REQ-011 SHALL provide port Clk  in  1  system clock (50 MHz).
REQ-012 SHALL provide port Reset  in  1  reset; reset Reset, synchronous, active-high; clock Clk.
REQ-013 SHALL provide port frame_clk  in  1  frame strobe (~60 Hz), asynchronous to nothing, sampled on Clk.
REQ-014 SHALL provide port keycode  in  8  current USB HID keycode (0x00 = none).
REQ-015 SHALL provide ports DrawX, DrawY  in  10 each  current pixel coordinate.
REQ-016 SHALL provide port is_char  out  1  pixel lies inside sprite box.
REQ-017 SHALL provide ports pos_x, pos_y  out  10 each  sprite centre.
REQ-018 SHALL provide ports facing_left, airborne, full  out  1 each  status flags.

Function
REQ-019 SHALL register frame_clk once and assert internal tick for exactly one Clk cycle, one cycle after a 0->1 frame_clk transition; all state updates occur only on tick.
REQ-020 SHALL use effective half-extent S = FULL_SIZE when full=1, else SIZE.
REQ-021 SHALL decode keycode on tick: 0x04 left, 0x07 right, 0x1A jump, 0x2C inhale, 0x16 release; any other value = no action.
REQ-022 SHALL keep states GROUND, AIR, INHALE; airborne=1 only in AIR.
REQ-023 GROUND/AIR, left: pos_x -= STEP, facing_left=1; right: pos_x += STEP, facing_left=0; result clamped to [X_MIN+S, X_MAX-S].
REQ-024 GROUND, jump: vel = -JUMP_V (signed 10-bit), state AIR, pos_y unchanged that tick.
REQ-025 AIR, each tick: pos_y += vel clamped to [Y_MIN+S, Y_MAX-S], then vel += 1 saturating at +MAX_FALL; top clamp forces vel=0.
REQ-026 AIR, when pos_y+vel+S >= Y_MAX: pos_y = Y_MAX-S, vel=0, state GROUND, same tick.
REQ-027 GROUND, inhale with full=0: state INHALE, counter=1; horizontal motion and jump ignored in INHALE.
REQ-028 INHALE, inhale still held: counter++; when counter reaches INHALE_FRAMES set full=1, state GROUND; any other key: counter=0, state GROUND.
REQ-029 full=1 and release key in GROUND or AIR: full=0 on that tick.
REQ-030 On full 0->1, pos_x and pos_y SHALL be re-clamped using FULL_SIZE on the same tick.
REQ-031 Inhale while AIR or while full=1 SHALL be ignored.
REQ-032 is_char SHALL be combinational: |DrawX-pos_x| <= S and |DrawY-pos_y| <= S, using unsigned-safe comparisons (no wrap at 0).

Reset
REQ-033 On Reset: pos_x=(X_MIN+X_MAX)/2 (319), pos_y=Y_MAX-SIZE (323), vel=0, state GROUND, counter=0, full=0, facing_left=0, airborne=0, tick=0.
REQ-034 Reset asserted mid-jump or mid-inhale SHALL override any tick in the same cycle.

Verification
REQ-035 Reset, keycode 0 for 10 frames -> pos=(319,323), all flags 0, no movement.
REQ-036 Hold 0x04 from reset -> pos_x decrements 1/frame, reaches 207 after 112 ticks, stays 207; facing_left=1.
REQ-037 Press 0x1A one frame then 0 -> pos_y sequence 317,312,308,305,303,302,302,303,305,308,312,317,323; airborne drops on last tick.
REQ-038 Hold 0x2C 30 frames at x=207 -> full=1 on 30th tick, pos_x re-clamped to 211; is_char at (219,323)=1; 0x16 -> full=0.
REQ-039 Hold 0x2C 15 frames, then 0x07 -> counter cleared, full stays 0, next tick moves right 1.
REQ-040 Assert Reset at jump apex (pos_y 302) -> next cycle pos_y=323, airborne=0.

Source files
------------

// File: rtl/character_motion_if.sv
// character_motion_if: frame strobe, key input, raster query and sprite status
interface character_motion_if;
  logic       frame_clk;
  logic [7:0] keycode;
  logic [9:0] DrawX, DrawY;
  logic       is_char;
  logic [9:0] pos_x, pos_y;
  logic       facing_left, airborne, full;
  modport master (output frame_clk, keycode, DrawX, DrawY,
                  input is_char, pos_x, pos_y, facing_left, airborne, full);
  modport slave (input frame_clk, keycode, DrawX, DrawY,
                 output is_char, pos_x, pos_y, facing_left, airborne, full);
endinterface

// File: rtl/character_motion.sv
// character_motion: frame-stepped sprite with walking, jump physics and inhale/full mode
module character_motion #(
  parameter int X_MIN = 203,
  parameter int X_MAX = 436,
  parameter int Y_MIN = 152,
  parameter int Y_MAX = 327,
  parameter int SIZE = 4,
  parameter int FULL_SIZE = 8,
  parameter int STEP = 1,
  parameter int JUMP_V = 6,
  parameter int MAX_FALL = 6,
  parameter int INHALE_FRAMES = 30
) (
  input logic Clk,
  input logic Reset,
  character_motion_if.slave bus
);
  typedef enum logic [1:0] {GROUND, AIR, INHALE} state_t;
  localparam int CW = $clog2(INHALE_FRAMES + 1);
  localparam logic signed [11:0] XL = 12'(X_MIN), XH = 12'(X_MAX), YL = 12'(Y_MIN), YH = 12'(Y_MAX);
  localparam logic signed [11:0] SZ = 12'(SIZE), FS = 12'(FULL_SIZE), ST = 12'(STEP), MF = 12'(MAX_FALL);
  localparam logic [7:0] K_LEFT = 8'h04, K_RIGHT = 8'h07, K_JUMP = 8'h1A, K_INHALE = 8'h2C, K_RELEASE = 8'h16;
  state_t state, state_n;
  logic frame_d, tick, full, full_n, facing_left, facing_left_n;
  logic [9:0] pos_x, pos_y, pos_x_n, pos_y_n, dx, dy;
  logic signed [9:0] vel, vel_n;
  logic [CW-1:0] cnt, cnt_n;
  logic signed [11:0] s, px, py, ny, mv;
  logic [7:0] key;

  function automatic logic signed [11:0] clamp(input logic signed [11:0] v,
                                               input logic signed [11:0] lo,
                                               input logic signed [11:0] hi);
    return v < lo ? lo : v > hi ? hi : v;
  endfunction

  assign key = bus.keycode;

  // Signed 12-bit working values keep clamps and velocity sums free of wraparound
  always_comb begin
    s = full ? FS : SZ;
    px = 12'(pos_x);
    py = 12'(pos_y);
    ny = py + 12'(vel);
    mv = state == INHALE ? 12'sd0 : key == K_LEFT ? -ST : key == K_RIGHT ? ST : 12'sd0;
    pos_x_n = 10'(clamp(px + mv, XL + s, XH - s));
    pos_y_n = pos_y;
    facing_left_n = state == INHALE || (key != K_LEFT && key != K_RIGHT) ? facing_left : key == K_LEFT;
    full_n = key == K_RELEASE && state != INHALE ? 1'b0 : full;
    state_n = state;
    vel_n = vel;
    cnt_n = cnt;
    case (state)
      GROUND:
        if (key == K_JUMP) begin
          vel_n = -10'(JUMP_V);
          state_n = AIR;
        end else if (key == K_INHALE && !full) begin
          cnt_n = CW'(1);
          state_n = INHALE;
        end
      AIR:
        if (ny + s >= YH) begin
          pos_y_n = 10'(YH - s);
          vel_n = '0;
          state_n = GROUND;
        end else if (ny < YL + s) begin
          pos_y_n = 10'(YL + s);
          vel_n = '0;
        end else begin
          pos_y_n = 10'(ny);
          vel_n = 12'(vel) >= MF ? 10'(MF) : vel + 10'sd1;
        end
      INHALE: begin
        cnt_n = '0;
        state_n = GROUND;
        if (key == K_INHALE && int'(cnt) + 1 >= INHALE_FRAMES) begin
          full_n = 1'b1;
          pos_x_n = 10'(clamp(px, XL + FS, XH - FS));
          pos_y_n = 10'(clamp(py, YL + FS, YH - FS));
        end else if (key == K_INHALE) begin
          cnt_n = cnt + 1'b1;
          state_n = INHALE;
        end
      end
      default: state_n = GROUND;
    endcase
  end

  always_ff @(posedge Clk) begin
    frame_d <= bus.frame_clk;
    if (Reset) begin
      tick <= 1'b0;
      state <= GROUND;
      pos_x <= 10'((X_MIN + X_MAX) / 2);
      pos_y <= 10'(Y_MAX - SIZE);
      vel <= '0;
      cnt <= '0;
      full <= 1'b0;
      facing_left <= 1'b0;
    end else begin
      tick <= bus.frame_clk & ~frame_d;
      if (tick) begin
        state <= state_n;
        pos_x <= pos_x_n;
        pos_y <= pos_y_n;
        vel <= vel_n;
        cnt <= cnt_n;
        full <= full_n;
        facing_left <= facing_left_n;
      end
    end
  end

  assign dx = bus.DrawX >= pos_x ? bus.DrawX - pos_x : pos_x - bus.DrawX;
  assign dy = bus.DrawY >= pos_y ? bus.DrawY - pos_y : pos_y - bus.DrawY;
  assign bus.is_char = dx <= 10'(s) && dy <= 10'(s);
  assign bus.pos_x = pos_x;
  assign bus.pos_y = pos_y;
  assign bus.facing_left = facing_left;
  assign bus.airborne = state == AIR;
  assign bus.full = full;
endmodule

// File: tb/tb_character_motion.sv
// tb_character_motion: directed frames checked every cycle against a rule-level motion model
module tb_character_motion;
  localparam int XMIN = 203, XMAX = 436, YMIN = 152, YMAX = 327;
  logic Clk = 0;
  logic Reset = 1;
  int checks = 0;
  int failures = 0;
  bit chk_en = 0;
  bit draw_fixed = 0;
  int mx, my, mv, mcnt, mode;
  bit mfull, mface;
  int seq[13] = '{317, 312, 308, 305, 303, 302, 302, 303, 305, 308, 312, 317, 323};

  character_motion_if bus();
  character_motion dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  always #5 Clk = ~Clk;

  function automatic int lim(int v, int lo, int hi);
    return v < lo ? lo : v > hi ? hi : v;
  endfunction

  function automatic int absd(int a, int b);
    return a > b ? a - b : b - a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    mx = (XMIN + XMAX) / 2;
    my = YMAX - 4;
    mv = 0;
    mcnt = 0;
    mode = 0;
    mfull = 0;
    mface = 0;
  endtask

  // mode: 0 on ground, 1 in air, 2 inhaling
  task automatic m_step(input logic [7:0] k);
    int s;
    s = mfull ? 8 : 4;
    if (mode != 2 && k == 8'h04) begin
      mx = lim(mx - 1, XMIN + s, XMAX - s);
      mface = 1;
    end
    if (mode != 2 && k == 8'h07) begin
      mx = lim(mx + 1, XMIN + s, XMAX - s);
      mface = 0;
    end
    if (mode != 2 && k == 8'h16) mfull = 0;
    if (mode == 0) begin
      if (k == 8'h1A) begin
        mv = -6;
        mode = 1;
      end else if (k == 8'h2C && !mfull) begin
        mode = 2;
        mcnt = 1;
      end
    end else if (mode == 1) begin
      if (my + mv + s >= YMAX) begin
        my = YMAX - s;
        mv = 0;
        mode = 0;
      end else if (my + mv < YMIN + s) begin
        my = YMIN + s;
        mv = 0;
      end else begin
        my += mv;
        mv = mv + 1 > 6 ? 6 : mv + 1;
      end
    end else begin
      mode = 0;
      if (k == 8'h2C) begin
        mcnt++;
        if (mcnt >= 30) begin
          mfull = 1;
          mcnt = 0;
          mx = lim(mx, XMIN + 8, XMAX - 8);
          my = lim(my, YMIN + 8, YMAX - 8);
        end else mode = 2;
      end else mcnt = 0;
    end
  endtask

  task automatic frame(input logic [7:0] k);
    @(negedge Clk);
    bus.keycode = k;
    bus.frame_clk = 1;
    @(posedge Clk);
    @(posedge Clk);
    m_step(k);
    @(negedge Clk);
    @(negedge Clk);
    bus.frame_clk = 0;
    @(negedge Clk);
  endtask

  task automatic frames(input logic [7:0] k, input int n);
    repeat (n) frame(k);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1;
    bus.frame_clk = 0;
    bus.keycode = 0;
    @(posedge Clk);
    m_reset();
    chk_en = 1;
    @(negedge Clk);
    Reset = 0;
  endtask

  initial forever begin
    @(posedge Clk);
    #2;
    if (chk_en) begin
      int s;
      s = mfull ? 8 : 4;
      chk("pos_x", bus.pos_x, mx);
      chk("pos_y", bus.pos_y, my);
      chk("facing_left", bus.facing_left, mface);
      chk("airborne", bus.airborne, mode == 1);
      chk("full", bus.full, mfull);
      chk("is_char", bus.is_char, absd(int'(bus.DrawX), mx) <= s && absd(int'(bus.DrawY), my) <= s);
    end
  end

  initial forever begin
    @(negedge Clk);
    if (!draw_fixed) begin
      bus.DrawX = 10'(mx + int'($urandom_range(22)) - 11);
      bus.DrawY = 10'(my + int'($urandom_range(22)) - 11);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.frame_clk = 0;
    bus.keycode = 0;
    bus.DrawX = 0;
    bus.DrawY = 0;
    do_reset();
    chk("reset_x", bus.pos_x, 319);
    chk("reset_y", bus.pos_y, 323);
    frames(8'h00, 10);
    chk("idle_x", bus.pos_x, 319);
    chk("idle_y", bus.pos_y, 323);
    chk("idle_flags", {bus.facing_left, bus.airborne, bus.full}, 0);
    frames(8'h04, 111);
    chk("left_111", bus.pos_x, 208);
    frame(8'h04);
    chk("left_112", bus.pos_x, 207);
    frames(8'h04, 3);
    chk("left_clamp", bus.pos_x, 207);
    chk("left_facing", bus.facing_left, 1);
    frame(8'h1A);
    chk("jump_tick_y", bus.pos_y, 323);
    chk("jump_air", bus.airborne, 1);
    for (int i = 0; i < 13; i++) begin
      frame(8'h00);
      chk("jump_seq_y", bus.pos_y, seq[i]);
      chk("jump_seq_air", bus.airborne, i < 12);
    end
    frames(8'h2C, 29);
    chk("inhale_29_full", bus.full, 0);
    frame(8'h2C);
    chk("inhale_30_full", bus.full, 1);
    chk("full_reclamp_x", bus.pos_x, 211);
    chk("full_reclamp_y", bus.pos_y, 319);
    @(negedge Clk);
    draw_fixed = 1;
    bus.DrawX = 219;
    bus.DrawY = 323;
    #1 chk("is_char_edge", bus.is_char, 1);
    bus.DrawX = 220;
    #1 chk("is_char_outx", bus.is_char, 0);
    bus.DrawX = 219;
    bus.DrawY = 328;
    #1 chk("is_char_outy", bus.is_char, 0);
    draw_fixed = 0;
    frame(8'h2C);
    chk("inhale_while_full", bus.full, 1);
    frame(8'h16);
    chk("release", bus.full, 0);
    frames(8'h2C, 15);
    frame(8'h07);
    chk("abort_no_move", bus.pos_x, 211);
    chk("abort_full", bus.full, 0);
    frame(8'h07);
    chk("abort_then_right", bus.pos_x, 212);
    chk("abort_facing", bus.facing_left, 0);
    frames(8'h2C, 3);
    frame(8'h1A);
    chk("jump_in_inhale", bus.airborne, 0);
    frames(8'h07, 230);
    chk("right_clamp", bus.pos_x, 432);
    frames(8'h2C, 30);
    chk("full_right_x", bus.pos_x, 428);
    frame(8'h1A);
    frame(8'h2C);
    frame(8'h04);
    chk("air_left", bus.pos_x, 427);
    frames(8'h00, 11);
    chk("full_land_y", bus.pos_y, 319);
    chk("full_land_air", bus.airborne, 0);
    chk("full_land_full", bus.full, 1);
    frame(8'h16);
    do_reset();
    frame(8'h1A);
    frames(8'h00, 6);
    chk("apex_y", bus.pos_y, 302);
    @(negedge Clk);
    bus.frame_clk = 1;
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1;
    bus.frame_clk = 0;
    @(posedge Clk);
    m_reset();
    #2;
    chk("reset_apex_y", bus.pos_y, 323);
    chk("reset_apex_air", bus.airborne, 0);
    @(negedge Clk);
    Reset = 0;
    frames(8'h00, 2);
    chk("post_reset_y", bus.pos_y, 323);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
